// File: rtl/load_store_unit.sv
// Load/store unit for a word-addressed data memory: RV32I load extraction and extension,
// plus read-modify-write for SB/SH. Optional define MISALIGN_TRAP_EN flags misaligned H/W accesses.
module load_store_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read_i,
    input  logic             mem_write_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             stall_o,
    output logic             misalign_o,
    output logic             dm_read_o,
    output logic             dm_write_o,
    output logic [WIDTH-1:0] dm_addr_o,
    output logic [WIDTH-1:0] dm_wdata_o,
    input  logic [WIDTH-1:0] dm_rdata_i
);

    typedef enum logic [0:0] {StIdle, StMerge} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] addr_q;
    logic [1:0]       size_q;
    logic [15:0]      wdata_q;

    logic             store_req;
    logic             load_req;
    logic             misalign;
    logic             sub_store;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged;

    // Both request lines high is treated as a store.
    assign store_req = mem_write_i &
                       (funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010);
    assign load_req  = mem_read_i & ~mem_write_i &
                       (funct3_i == 3'b000 || funct3_i == 3'b001 || funct3_i == 3'b010 ||
                        funct3_i == 3'b100 || funct3_i == 3'b101);

`ifdef MISALIGN_TRAP_EN
    assign misalign = (load_req | store_req) &
                      (((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                       ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign sub_store = store_req & ~misalign & (funct3_i != 3'b010);

    always_comb begin
        ld_byte = dm_rdata_i[7:0];
        case (addr_i[1:0])
            2'b00:   ld_byte = dm_rdata_i[7:0];
            2'b01:   ld_byte = dm_rdata_i[15:8];
            2'b10:   ld_byte = dm_rdata_i[23:16];
            default: ld_byte = dm_rdata_i[31:24];
        endcase
    end

    assign ld_half = addr_i[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];

    always_comb begin
        load_data = '0;
        case (funct3_i)
            3'b000:  load_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
            3'b010:  load_data = dm_rdata_i;
            3'b100:  load_data = {{(WIDTH-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(WIDTH-16){1'b0}}, ld_half};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        merged = merge_q;
        if (size_q == 2'b00) begin
            case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            merge_q <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (sub_store) begin
                        state_q <= StMerge;
                        merge_q <= dm_rdata_i;
                        addr_q  <= addr_i;
                        size_q  <= funct3_i[1:0];
                        wdata_q <= wdata_i[15:0];
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are combinational from the current state; reset forces them all low.
    always_comb begin
        dm_read_o  = 1'b0;
        dm_write_o = 1'b0;
        dm_addr_o  = {addr_i[WIDTH-1:2], 2'b00};
        dm_wdata_o = '0;
        rdata_o    = '0;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        if (!rst_n) begin
            dm_addr_o = '0;
        end else if (state_q == StMerge) begin
            dm_write_o = 1'b1;
            dm_addr_o  = {addr_q[WIDTH-1:2], 2'b00};
            dm_wdata_o = merged;
        end else begin
            misalign_o = misalign;
            if (store_req && !misalign) begin
                if (funct3_i == 3'b010) begin
                    dm_write_o = 1'b1;
                    dm_wdata_o = wdata_i;
                end else begin
                    dm_read_o = 1'b1;
                    stall_o   = 1'b1;
                end
            end else if (load_req && !misalign) begin
                dm_read_o = 1'b1;
                rdata_o   = load_data;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random accesses against a byte-level
// memory model; honours MISALIGN_TRAP_EN when defined.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o, dm_addr_o, dm_wdata_o, dm_rdata_i;
    logic        stall_o, misalign_o, dm_read_o, dm_write_o;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] r, wd;

    always #5 clk = ~clk;

    load_store_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read_i (mem_read_i),
        .mem_write_i(mem_write_i),
        .funct3_i   (funct3_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .stall_o    (stall_o),
        .misalign_o (misalign_o),
        .dm_read_o  (dm_read_o),
        .dm_write_o (dm_write_o),
        .dm_addr_o  (dm_addr_o),
        .dm_wdata_o (dm_wdata_o),
        .dm_rdata_i (dm_rdata_i)
    );

    // Word-addressed memory with combinational read and clocked whole-word write.
    assign dm_rdata_i = mem[dm_addr_o[7:2]];
    always @(posedge clk) if (dm_write_o) mem[dm_addr_o[7:2]] <= dm_wdata_o;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        funct3_i    = 3'b000;
        addr_i      = 32'h0;
        wdata_i     = 32'h0;
    endtask

    // One access: drive at negedge, check the combinational cycle, then the merge cycle if any.
    task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] obs_r, output logic [31:0] obs_wd);
        logic        st_ok, ld_ok, mis, sub, sw;
        logic [31:0] w, exp_r, bv, hv, exp_w;
        int          sh, hsh;
        st_ok = wr && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        ld_ok = rd && !wr && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if ((st_ok || ld_ok) && ((f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00)))
            mis = 1'b1;
`endif
        sw    = st_ok && !mis && f3 == 3'd2;
        sub   = st_ok && !mis && f3 != 3'd2;
        w     = ref_mem[a[7:2]];
        sh    = 8 * int'(a[1:0]);
        hsh   = a[1] ? 16 : 0;
        bv    = (w >> sh) & 32'hFF;
        hv    = (w >> hsh) & 32'hFFFF;
        exp_r = 32'h0;
        if (ld_ok && !mis) begin
            case (f3)
                3'd0:    exp_r = bv[7] ? bv - 32'h100 : bv;
                3'd4:    exp_r = bv;
                3'd1:    exp_r = hv[15] ? hv - 32'h10000 : hv;
                3'd5:    exp_r = hv;
                default: exp_r = w;
            endcase
        end
        exp_w = w;
        if (st_ok && f3 == 3'd0) exp_w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
        if (st_ok && f3 == 3'd1) exp_w = (w & ~(32'hFFFF << hsh)) | ((d & 32'hFFFF) << hsh);
        if (sw) exp_w = d;

        @(negedge clk);
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = a; wdata_i = d;
        #1;
        obs_r  = rdata_o;
        obs_wd = dm_wdata_o;
        check_eq("misalign", {31'b0, misalign_o}, {31'b0, mis});
        check_eq("rdata", rdata_o, exp_r);
        check_eq("dm_read", {31'b0, dm_read_o}, {31'b0, (ld_ok && !mis) || sub});
        check_eq("dm_write", {31'b0, dm_write_o}, {31'b0, sw});
        check_eq("stall", {31'b0, stall_o}, {31'b0, sub});
        if ((ld_ok || st_ok) && !mis) check_eq("dm_addr", dm_addr_o, {a[31:2], 2'b00});
        if (sw) check_eq("sw_wdata", dm_wdata_o, d);
        @(posedge clk);
        #1;
        if (sub) begin
            // Inputs during the merge cycle must be ignored.
            mem_read_i  = 1'($urandom);
            mem_write_i = 1'($urandom);
            funct3_i    = 3'($urandom);
            addr_i      = {24'h0, 8'($urandom)};
            wdata_i     = $urandom;
            #1;
            obs_wd = dm_wdata_o;
            check_eq("merge_write", {31'b0, dm_write_o}, 32'd1);
            check_eq("merge_read", {31'b0, dm_read_o}, 32'd0);
            check_eq("merge_stall", {31'b0, stall_o}, 32'd0);
            check_eq("merge_addr", dm_addr_o, {a[31:2], 2'b00});
            check_eq("merge_wdata", dm_wdata_o, exp_w);
            check_eq("merge_rdata", rdata_o, 32'h0);
            @(posedge clk);
            #1;
        end
        ref_mem[a[7:2]] = exp_w;
        idle_inputs();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[2]     = 32'h80FF7F01;
        ref_mem[2] = 32'h80FF7F01;

        // Reset with a store request present: everything must stay quiet.
        rst_n = 1'b0;
        idle_inputs();
        mem_write_i = 1'b1;
        addr_i      = 32'h9;
        #1;
        check_eq("rst_dm_write", {31'b0, dm_write_o}, 32'd0);
        check_eq("rst_stall", {31'b0, stall_o}, 32'd0);
        check_eq("rst_rdata", rdata_o, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        do_op(1'b1, 1'b0, 3'd0, 32'h9, 32'h0, r, wd); check_eq("lb_9", r, 32'h0000007F);
        do_op(1'b1, 1'b0, 3'd0, 32'hA, 32'h0, r, wd); check_eq("lb_a", r, 32'hFFFFFFFF);
        do_op(1'b1, 1'b0, 3'd4, 32'hB, 32'h0, r, wd); check_eq("lbu_b", r, 32'h00000080);
        do_op(1'b1, 1'b0, 3'd1, 32'hA, 32'h0, r, wd); check_eq("lh_a", r, 32'hFFFF80FF);
        do_op(1'b1, 1'b0, 3'd5, 32'hA, 32'h0, r, wd); check_eq("lhu_a", r, 32'h000080FF);
        do_op(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, r, wd); check_eq("lw_8", r, 32'h80FF7F01);
        do_op(1'b0, 1'b1, 3'd0, 32'h9, 32'h123456AB, r, wd); check_eq("sb_9", wd, 32'h80FFAB01);
        do_op(1'b0, 1'b1, 3'd2, 32'h8, 32'h80FF7F01, r, wd);
        do_op(1'b0, 1'b1, 3'd1, 32'hA, 32'h00001234, r, wd);
        check_eq("sh_a_mem", mem[2], 32'h12347F01);
        do_op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, r, wd);
        check_eq("sw_10_mem", mem[4], 32'hDEADBEEF);
        do_op(1'b1, 1'b0, 3'd2, 32'h6, 32'h0, r, wd);
        do_op(1'b1, 1'b1, 3'd0, 32'h11, 32'h000000C3, r, wd);
        do_op(1'b1, 1'b0, 3'd3, 32'h8, 32'h0, r, wd);
        do_op(1'b0, 1'b1, 3'd6, 32'h8, 32'h5555AAAA, r, wd);

        // Reset during the merge cycle drops the write.
        @(negedge clk);
        mem_write_i = 1'b1; funct3_i = 3'd0; addr_i = 32'h9; wdata_i = 32'h000000A5;
        @(posedge clk);
        #1;
        idle_inputs();
        check_eq("pre_rst_merge", {31'b0, dm_write_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_merge_write", {31'b0, dm_write_o}, 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_merge_mem", mem[2], ref_mem[2]);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, r, wd);
        check_eq("post_rst_lw", r, 32'h12347F01);

        for (int i = 0; i < 300; i++) begin
            logic [1:0] kind;
            kind = 2'($urandom);
            do_op(kind[0], kind[1], 3'($urandom), {24'h0, 8'($urandom)}, $urandom, r, wd);
        end

        for (int i = 0; i < 64; i++) check_eq("final_mem", mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
